// File: rtl/keypad_scan.sv
// keypad_scan -- 4x4 matrix keypad scanner with debounce.
//
// Drives one column low at a time, watches the synchronized rows, debounces
// a press and a release, and reports the key as row*4 + col.
//
// Parameters:
//   SCAN_DIV   - clk cycles each column is driven while scanning (>= 4)
//   DEB_CNT    - consecutive stable cycles to accept a press/release (>= 2)
//   REPEAT_CNT - auto-repeat interval in clk cycles (repeat build only)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   row_in    in   [3:0] rows, active-low, asynchronous to clk
//   col_out   out  [3:0] column drive, active-low one-hot
//   key_code  out  [3:0] last accepted key, row*4 + col
//   key_valid out  one-cycle pulse when key_code is (re)issued
//   key_held  out  high while the accepted key is considered pressed
//
// Optional feature: define KEYPAD_REPEAT_EN to re-pulse key_valid every
// REPEAT_CNT cycles while the key stays pressed.

module keypad_scan #(
    parameter logic [19:0] SCAN_DIV   = 20'd50000,
    parameter logic [19:0] DEB_CNT    = 20'd1000000,
    parameter logic [25:0] REPEAT_CNT = 26'd25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    if (SCAN_DIV < 20'd4 || DEB_CNT < 20'd2 || REPEAT_CNT < 26'd1) begin : g_param_check
        $error("keypad_scan: parameter below its minimum");
    end

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    state_t      state;
    logic [3:0]  rs_meta;
    logic [3:0]  rs;
    logic [3:0]  pat;
    logic [1:0]  col;
    logic [19:0] dwell_cnt;
    logic [19:0] deb_cnt;
`ifdef KEYPAD_REPEAT_EN
    logic [25:0] rep_cnt;
`endif

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        col_drive = ~(4'b0001 << c);
    endfunction

    // Lowest-index low row wins when several rows are low in one column.
    function automatic logic [1:0] low_row(input logic [3:0] p);
        casez (p)
            4'b???0: low_row = 2'd0;
            4'b??01: low_row = 2'd1;
            4'b?011: low_row = 2'd2;
            default: low_row = 2'd3;
        endcase
    endfunction

    // Two-flop synchronizer; nothing downstream looks at row_in directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_meta <= '1;
            rs      <= '1;
        end else begin
            rs_meta <= row_in;
            rs      <= rs_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_SCAN;
            col       <= 2'd0;
            col_out   <= 4'b1110;
            dwell_cnt <= SCAN_DIV - 20'd1;
            deb_cnt   <= '0;
            pat       <= '1;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            case (state)
                S_SCAN: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 20'd1;
                    end else if (rs == 4'b1111) begin
                        col       <= col + 2'd1;
                        col_out   <= col_drive(col + 2'd1);
                        dwell_cnt <= SCAN_DIV - 20'd1;
                    end else begin
                        pat     <= rs;
                        deb_cnt <= DEB_CNT - 20'd1;
                        state   <= S_DEBOUNCE;
                    end
                end

                S_DEBOUNCE: begin
                    if (rs != pat) begin
                        dwell_cnt <= SCAN_DIV - 20'd1;
                        state     <= S_SCAN;
                    end else if (deb_cnt == '0) begin
                        key_code  <= {low_row(pat), col};
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        state     <= S_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt   <= REPEAT_CNT - 26'd1;
`endif
                    end else begin
                        deb_cnt <= deb_cnt - 20'd1;
                    end
                end

                S_PRESSED: begin
                    if (rs == 4'b1111) begin
                        deb_cnt <= DEB_CNT - 20'd1;
                        state   <= S_RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    // Repeat timer keeps its value across release bounces.
                    else if (rep_cnt == '0) begin
                        key_valid <= 1'b1;
                        rep_cnt   <= REPEAT_CNT - 26'd1;
                    end else begin
                        rep_cnt <= rep_cnt - 26'd1;
                    end
`endif
                end

                S_RELEASE: begin
                    if (rs != 4'b1111) begin
                        state <= S_PRESSED;
                    end else if (deb_cnt == '0) begin
                        key_held  <= 1'b0;
                        col       <= col + 2'd1;
                        col_out   <= col_drive(col + 2'd1);
                        dwell_cnt <= SCAN_DIV - 20'd1;
                        state     <= S_SCAN;
                    end else begin
                        deb_cnt <= deb_cnt - 20'd1;
                    end
                end

                default: state <= S_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEB_CNT=8, REPEAT_CNT=20.
// A small key-matrix model turns per-column pressed-row masks into row_in
// according to the column currently driven. Cycle numbers Nk refer to the
// k-th falling edge after reset release (N0 = the release edge).
`timescale 1ns/1ps

module tb_keypad_scan;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] mask0, mask1, mask2, mask3;

    int checks;
    int errors;

    keypad_scan #(
        .SCAN_DIV   (20'd4),
        .DEB_CNT    (20'd8),
        .REPEAT_CNT (26'd20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    assign row_in = ~(((col_out[0] == 1'b0) ? mask0 : 4'h0) |
                      ((col_out[1] == 1'b0) ? mask1 : 4'h0) |
                      ((col_out[2] == 1'b0) ? mask2 : 4'h0) |
                      ((col_out[3] == 1'b0) ? mask3 : 4'h0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Leaves the bench at N0 with rst just released.
    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        mask0 = 4'h0;
        mask1 = 4'h0;
        mask2 = 4'h0;
        mask3 = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (col_out !== 4'b1110) begin
            errors++;
            $display("FAIL reset_col_out: got %b expected 1110", col_out);
        end
        checks++;
        if (key_code !== 4'h0) begin
            errors++;
            $display("FAIL reset_key_code: got %h expected 0", key_code);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_key_valid: got %b expected 0", key_valid);
        end
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_key_held: got %b expected 0", key_held);
        end
        rst = 1'b0;
    endtask

    // Column k/4 mod 4 is driven at Nk; no key pressed, so no key_valid.
    task automatic test_idle_scan();
        logic [3:0] exp_col;
        for (int unsigned k = 0; k < 100; k++) begin
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (col_out !== exp_col || key_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_scan N%0d: col_out=%b key_valid=%b expected col_out=%b key_valid=0",
                         k, col_out, key_valid, exp_col);
            end
            @(negedge clk);
        end
    endtask

    // Row 2 on column 1: detected at the end of column-1 dwell, accepted at N16.
    task automatic press_r2c1_to_accept(output int pulses);
        do_reset();
        mask1 = 4'b0100;
        pulses = 0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (key_valid === 1'b1) pulses++;
            @(negedge clk);
        end
    endtask

    task automatic test_press();
        int pulses;
        press_r2c1_to_accept(pulses);
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL press_early_valid: got %0d pulses before N16 expected 0", pulses);
        end
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h9 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL press_accept: valid=%b code=%h held=%b expected valid=1 code=9 held=1",
                     key_valid, key_code, key_held);
        end
        pulses = 0;
        for (int unsigned k = 0; k < 20; k++) begin
            @(negedge clk);
            if (key_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL press_single_pulse: got %0d extra pulses expected 0", pulses);
        end
        checks++;
        if (col_out !== 4'b1101 || key_held !== 1'b1 || key_code !== 4'h9) begin
            errors++;
            $display("FAIL press_frozen: col_out=%b held=%b code=%h expected 1101 1 9",
                     col_out, key_held, key_code);
        end
    endtask

    // Row 0 on column 0 low N0..N5 only: debounce aborts, column 0 redwells.
    task automatic test_glitch();
        int pulses;
        do_reset();
        mask0 = 4'b0001;
        pulses = 0;
        for (int unsigned k = 0; k < 11; k++) begin
            if (k == 5) mask0 = 4'h0;
            if (key_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (col_out !== 4'b1110) begin
            errors++;
            $display("FAIL glitch_same_col N11: col_out=%b expected 1110", col_out);
        end
        @(negedge clk);
        checks++;
        if (col_out !== 4'b1101) begin
            errors++;
            $display("FAIL glitch_resume N12: col_out=%b expected 1101", col_out);
        end
        for (int unsigned k = 0; k < 8; k++) begin
            if (key_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0 || key_held !== 1'b0 || key_code !== 4'h0) begin
            errors++;
            $display("FAIL glitch_no_key: pulses=%0d held=%b code=%h expected 0 0 0",
                     pulses, key_held, key_code);
        end
    endtask

    // Bounce N16..N45 in 3-cycle halves, release for good at N46;
    // release completes at N57 and scanning moves to column 2.
    task automatic test_bounce();
        int pulses;
        int held_drop;
        press_r2c1_to_accept(pulses);
        pulses    = 0;
        held_drop = 0;
        for (int unsigned k = 16; k < 57; k++) begin
            if (k >= 16 && k < 46)
                mask1 = (((k - 16) / 3) % 2 == 0) ? 4'h0 : 4'b0100;
            else
                mask1 = 4'h0;
            if (k > 16 && key_valid === 1'b1) pulses++;
            if (key_held !== 1'b1) held_drop++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL bounce_extra_valid: got %0d pulses expected 0", pulses);
        end
        checks++;
        if (held_drop != 0) begin
            errors++;
            $display("FAIL bounce_held_drop: key_held low on %0d cycles expected 0", held_drop);
        end
        checks++;
        if (key_held !== 1'b0 || col_out !== 4'b1011 || key_code !== 4'h9) begin
            errors++;
            $display("FAIL bounce_release N57: held=%b col_out=%b code=%h expected 0 1011 9",
                     key_held, col_out, key_code);
        end
    endtask

    // Rows 1 and 3 on column 2: accepted at N20 as row 1.
    task automatic test_multi_row();
        do_reset();
        mask2 = 4'b1010;
        repeat (20) @(negedge clk);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h6 || col_out !== 4'b1011) begin
            errors++;
            $display("FAIL multi_row: valid=%b code=%h col_out=%b expected 1 6 1011",
                     key_valid, key_code, col_out);
        end
    endtask

    // Key held until N86, then reset asserted mid-press.
    task automatic test_hold_and_reset();
        int pulses;
        int exp_pulses;
        press_r2c1_to_accept(pulses);
`ifdef KEYPAD_REPEAT_EN
        exp_pulses = 4;
`else
        exp_pulses = 1;
`endif
        for (int unsigned k = 16; k < 86; k++) begin
            if (key_valid === 1'b1) pulses++;
`ifdef KEYPAD_REPEAT_EN
            if (k == 36 || k == 56 || k == 76) begin
                checks++;
                if (key_valid !== 1'b1 || key_code !== 4'h9) begin
                    errors++;
                    $display("FAIL repeat_pulse N%0d: valid=%b code=%h expected 1 9",
                             k, key_valid, key_code);
                end
            end
`endif
            @(negedge clk);
        end
        if (key_valid === 1'b1) pulses++;
        checks++;
        if (pulses != exp_pulses) begin
            errors++;
            $display("FAIL hold_pulse_count: got %0d expected %0d", pulses, exp_pulses);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (col_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL midpress_reset: col_out=%b code=%h valid=%b held=%b expected 1110 0 0 0",
                     col_out, key_code, key_valid, key_held);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_release: valid=%b held=%b expected 0 0", key_valid, key_held);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        mask0  = 4'h0;
        mask1  = 4'h0;
        mask2  = 4'h0;
        mask3  = 4'h0;
        repeat (2) @(negedge clk);
        test_reset();
        test_idle_scan();
        test_press();
        test_glitch();
        test_bounce();
        test_multi_row();
        test_hold_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
